// File: rtl/vm2002_pkg.sv
// Shared types and constants for the vm2002 coin acceptor.
// Holds coin_t, lane FSM states and default parameters.
package vm2002_pkg;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    NICKEL  = 3'd1,
    DIME    = 3'd2,
    QUARTER = 3'd3,
    DOLLAR  = 3'd4
  } coin_t;

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_COUNT   = 2'd1,
    L_LATCHED = 2'd2
  } lane_st_t;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int COIN_FIFO_DEPTH = 4;

endpackage

// File: rtl/vm2002_coin_lane.sv
// One coin-slot lane: debounces a raw sensor into a single recognition pulse.
// Ports: clk, hrst_n (sync, active-low), sense_i (raw), rec_o (1-cycle pulse).
module vm2002_coin_lane
  import vm2002_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic hrst_n,
  input  logic sense_i,
  output logic rec_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  lane_st_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      state_q <= L_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the number of consecutive high samples already seen;
  // the pulse fires combinationally on the DEBOUNCE-th one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_o   = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        if (sense_i) begin
          if (DEBOUNCE == 1) begin
            state_d = L_LATCHED;
            rec_o   = 1'b1;
          end else begin
            state_d = L_COUNT;
            cnt_d   = CW'(1);
          end
        end
      end
      L_COUNT: begin
        if (!sense_i) begin
          state_d = L_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
          state_d = L_LATCHED;
          cnt_d   = '0;
          rec_o   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      L_LATCHED: begin
        if (!sense_i) state_d = L_IDLE;
      end
      default: begin
        state_d = L_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/vm2002_coin_acceptor.sv
// Coin acceptor: four debounced lanes, jam/overflow returns, coin FIFO, issue.
// Ports: clk, hrst_n, sense[3:0], hold in; coins, ret_valid, ret_coin, fifo_full, reject_cnt out.
module vm2002_coin_acceptor
  import vm2002_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_CYCLES,
  parameter int DEPTH    = COIN_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       hrst_n,
  input  logic [3:0] sense,
  input  logic       hold,
  output coin_t      coins,
  output logic       ret_valid,
  output coin_t      ret_coin,
  output logic       fifo_full,
  output logic [7:0] reject_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [3:0] rec;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    vm2002_coin_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clk     (clk),
      .hrst_n  (hrst_n),
      .sense_i (sense[g]),
      .rec_o   (rec[g])
    );
  end

  coin_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  coin_t         coins_q, coins_d;
  logic          ret_valid_q, ret_valid_d;
  coin_t         ret_coin_q, ret_coin_d;
  logic [7:0]    rej_q, rej_d;

  logic  any_rec, jam, full, push, pop;
  coin_t rec_coin;

  always_comb begin
    any_rec = |rec;
    jam     = (rec & (rec - 4'd1)) != 4'd0;
    case (rec)
      4'b0001: rec_coin = NICKEL;
      4'b0010: rec_coin = DIME;
      4'b0100: rec_coin = QUARTER;
      4'b1000: rec_coin = DOLLAR;
      default: rec_coin = NONE;
    endcase
    // Fullness is judged on the registered count, before any pop this cycle.
    full = cnt_q == NW'(DEPTH);
    push = any_rec && !jam && !full;
    // The coins_q == NONE term spaces issued coins by at least one idle cycle.
    pop  = (cnt_q != '0) && !hold && (coins_q == NONE);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + NW'(push) - NW'(pop);
    coins_d  = pop ? mem_q[rd_ptr_q] : NONE;

    ret_valid_d = any_rec && (jam || full);
    ret_coin_d  = jam ? NONE : rec_coin;
    rej_d       = (jam && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
  end

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      coins_q     <= NONE;
      ret_valid_q <= 1'b0;
      ret_coin_q  <= NONE;
      rej_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      coins_q     <= coins_d;
      ret_valid_q <= ret_valid_d;
      ret_coin_q  <= ret_coin_d;
      rej_q       <= rej_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (hrst_n && push) mem_q[wr_ptr_q] <= rec_coin;
  end

  assign coins      = coins_q;
  assign ret_valid  = ret_valid_q;
  assign ret_coin   = ret_coin_q;
  assign fifo_full  = full;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// Scoreboard bench for vm2002_coin_acceptor: queue-based reference model,
// directed scenarios plus randomized sensor/hold/reset traffic.
module tb_vm2002_coin_acceptor;
  import vm2002_pkg::*;

  localparam int DEB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       hrst_n = 1'b0;
  logic [3:0] sense = 4'd0;
  logic       hold = 1'b0;
  coin_t      coins;
  logic       ret_valid;
  coin_t      ret_coin;
  logic       fifo_full;
  logic [7:0] reject_cnt;

  always #5 clk = ~clk;

  vm2002_coin_acceptor #(.DEBOUNCE(DEB), .DEPTH(DEP)) dut (
    .clk        (clk),
    .hrst_n     (hrst_n),
    .sense      (sense),
    .hold       (hold),
    .coins      (coins),
    .ret_valid  (ret_valid),
    .ret_coin   (ret_coin),
    .fifo_full  (fifo_full),
    .reject_cnt (reject_cnt)
  );

  typedef struct {
    int    cyc;
    coin_t c;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  exp_t  exp_coin_q[$];
  exp_t  exp_ret_q[$];

  // Reference model state
  coin_t fifo_m[$];
  int    run_m[4];
  bit    prev_issued;
  int    rej_m;
  bit    full_m;
  int    nrec;
  coin_t rc;
  bit    was_full;

  function automatic coin_t lane2coin(int l);
    case (l)
      0: return NICKEL;
      1: return DIME;
      2: return QUARTER;
      default: return DOLLAR;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a coin is recognised when a lane's run of high samples reaches
  // exactly DEB; the FIFO is a plain queue.
  initial begin
    foreach (run_m[i]) run_m[i] = 0;
    prev_issued = 0;
    rej_m = 0;
    full_m = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!hrst_n) begin
        foreach (run_m[i]) run_m[i] = 0;
        fifo_m.delete();
        prev_issued = 0;
        rej_m = 0;
      end else begin
        nrec = 0;
        rc = NONE;
        for (int l = 0; l < 4; l++) begin
          if (sense[l]) begin
            if (run_m[l] <= DEB) run_m[l]++;
            if (run_m[l] == DEB) begin
              nrec++;
              rc = lane2coin(l);
            end
          end else begin
            run_m[l] = 0;
          end
        end
        was_full = fifo_m.size() == DEP;
        if (fifo_m.size() > 0 && !hold && !prev_issued) begin
          exp_coin_q.push_back('{cyc: cyc, c: fifo_m.pop_front()});
          prev_issued = 1;
        end else begin
          prev_issued = 0;
        end
        if (nrec >= 2) begin
          if (rej_m < 255) rej_m++;
          exp_ret_q.push_back('{cyc: cyc, c: NONE});
        end else if (nrec == 1) begin
          if (was_full) exp_ret_q.push_back('{cyc: cyc, c: rc});
          else fifo_m.push_back(rc);
        end
      end
      full_m = fifo_m.size() == DEP;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a coin or return.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("fifo_full", int'(fifo_full), int'(full_m));
      chk("reject_cnt", int'(reject_cnt), rej_m);
      if (coins != NONE) begin
        if (exp_coin_q.size() == 0) begin
          chk("coins_unexpected", int'(coins), int'(NONE));
        end else begin
          e = exp_coin_q.pop_front();
          chk("coins_value", int'(coins), int'(e.c));
          chk("coins_cycle", cyc, e.cyc);
        end
      end else if (exp_coin_q.size() > 0 && exp_coin_q[0].cyc <= cyc) begin
        e = exp_coin_q.pop_front();
        chk("coins_missing", int'(coins), int'(e.c));
      end
      if (ret_valid) begin
        if (exp_ret_q.size() == 0) begin
          chk("ret_unexpected", int'(ret_valid), 0);
        end else begin
          e = exp_ret_q.pop_front();
          chk("ret_coin", int'(ret_coin), int'(e.c));
          chk("ret_cycle", cyc, e.cyc);
        end
      end else if (exp_ret_q.size() > 0 && exp_ret_q[0].cyc <= cyc) begin
        e = exp_ret_q.pop_front();
        chk("ret_missing", int'(ret_valid), 1);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(int l, int len);
    sense[l] = 1'b1;
    tick(len);
    sense[l] = 1'b0;
    tick(2);
  endtask

  initial begin
    hrst_n = 1'b0;
    tick(2);
    hrst_n = 1'b1;
    tick(1);
    chk("reset_reject_cnt", int'(reject_cnt), 0);
    chk("reset_coins", int'(coins), int'(NONE));

    // Single quarter held 6 cycles
    put(2, 6);
    tick(8);
    // Glitch shorter than the debounce window
    put(0, 3);
    tick(6);
    // Jam on dime and dollar lanes
    sense = 4'b1010;
    tick(4);
    sense = 4'b0000;
    tick(4);
    chk("jam_reject_cnt", int'(reject_cnt), 1);

    // Overflow while held
    hold = 1'b1;
    put(1, 5);
    put(0, 5);
    put(1, 5);
    put(3, 5);
    chk("overflow_full", int'(fifo_full), 1);
    put(2, 5);
    tick(2);
    hold = 1'b0;
    tick(12);
    chk("drained_full", int'(fifo_full), 0);

    // Reset with coins queued
    hold = 1'b1;
    put(0, 5);
    put(1, 5);
    hrst_n = 1'b0;
    tick(1);
    hrst_n = 1'b1;
    chk("rst_mid_full", int'(fifo_full), 0);
    chk("rst_mid_reject", int'(reject_cnt), 0);
    hold = 1'b0;
    tick(10);

    // Reject counter saturation
    repeat (260) begin
      sense = 4'b0011;
      tick(4);
      sense = 4'b0000;
      tick(1);
    end
    tick(2);
    chk("sat_reject_cnt", int'(reject_cnt), 255);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < 4; l++)
        if ($urandom_range(7) == 0) sense[l] = ~sense[l];
      if ($urandom_range(5) == 0) hold = ~hold;
      hrst_n = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    sense = 4'd0;
    hold = 1'b0;
    hrst_n = 1'b1;
    tick(40);
    @(negedge clk);
    chk("coin_queue_drained", exp_coin_q.size(), 0);
    chk("ret_queue_drained", exp_ret_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
